// File: rtl/psum_act_writeback_pkg.sv
// Shared constants, FSM encoding and FIFO entry type for the psum activation/writeback block.
package psum_act_writeback_pkg;
    localparam int LANES      = 10;
    localparam int PSUM_W     = 16;
    localparam int OUT_W      = 8;
    localparam int ALPHA_FRAC = 6;
    localparam int OUT_SHIFT  = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 16;
    localparam int CNT_W      = 16;

    localparam int STREAM_W = 176;
    localparam int PSUM_LSB = 16;
    localparam int ROW_LSB  = 8;
    localparam int COL_LSB  = 0;

    localparam int SUM_W = PSUM_W + 1;
    localparam int ACT_W = SUM_W + OUT_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3
    } wb_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]        addr;
        logic [LANES*OUT_W-1:0]   data;
    } wr_entry_t;
endpackage

// File: rtl/psum_act_writeback_if.sv
// Input psum stream plus output-buffer write port; slave is the writeback block's view.
interface psum_act_writeback_if;
    import psum_act_writeback_pkg::*;

    logic                     s_valid;
    logic                     s_ready;
    logic [STREAM_W-1:0]      s_data;
    logic                     wr_en;
    logic                     wr_ready;
    logic [ADDR_W-1:0]        wr_addr;
    logic [LANES*OUT_W-1:0]   wr_data;

    modport slave  (input  s_valid, s_data, wr_ready,
                    output s_ready, wr_en, wr_addr, wr_data);
    modport master (output s_valid, s_data, wr_ready,
                    input  s_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/psum_act_writeback_prelu_q_lane.sv
// One lane: bias add (S1), PReLU (S2), round + int8 saturate (S3, combinational into the FIFO write).
module prelu_q_lane
    import psum_act_writeback_pkg::*;
(
    input  logic                     clk,
    input  logic signed [PSUM_W-1:0] psum,
    input  logic signed [PSUM_W-1:0] bias,
    input  logic signed [OUT_W-1:0]  alpha,
    output logic signed [OUT_W-1:0]  q
);
    localparam logic signed [ACT_W-1:0] RND   = ACT_W'(1 << (OUT_SHIFT - 1));
    localparam logic signed [ACT_W-1:0] Q_MAX = ACT_W'(127);
    localparam logic signed [ACT_W-1:0] Q_MIN = -ACT_W'(128);

    logic signed [SUM_W-1:0] sum_d, sum_q;
    logic signed [ACT_W-1:0] act_d, act_q, prod, shifted;

    always_comb begin
        sum_d   = {psum[PSUM_W-1], psum} + {bias[PSUM_W-1], bias};
        prod    = ACT_W'(sum_q) * ACT_W'(alpha);
        act_d   = sum_q[SUM_W-1] ? (prod >>> ALPHA_FRAC) : ACT_W'(sum_q);
        // Adding half an LSB before the floor shift gives round-half-up.
        shifted = (act_q + RND) >>> OUT_SHIFT;
        if (shifted > Q_MAX)      q = Q_MAX[OUT_W-1:0];
        else if (shifted < Q_MIN) q = Q_MIN[OUT_W-1:0];
        else                      q = shifted[OUT_W-1:0];
    end

    always_ff @(posedge clk) begin
        sum_q <= sum_d;
        act_q <= act_d;
    end
endmodule

// File: rtl/psum_act_writeback.sv
// Bias/PReLU/int8 writeback: 3-stage lane pipeline feeding a small write FIFO, tile FSM counts beats.
module psum_act_writeback
    import psum_act_writeback_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W-1:0]          expected_cnt,
    input  logic [ADDR_W-1:0]         out_base_addr,
    input  logic [7:0]                out_wid,
    input  logic [LANES*PSUM_W-1:0]   bias,
    input  logic [LANES*OUT_W-1:0]    alpha,
    output logic                      busy,
    output logic                      done,
    psum_act_writeback_if.slave       bus
);
    wb_state_e                   state_q, state_d;
    logic [CNT_W-1:0]            exp_q, exp_d, acc_q, acc_d, wcnt_q, wcnt_d;
    logic [ADDR_W-1:0]           base_q, base_d, addr1_q, addr1_d, addr2_q;
    logic [7:0]                  wid_q, wid_d;
    logic [1:0]                  vld_pipe_q;
    logic [PTR_W-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FCNT_W-1:0]           fcnt_q, fcnt_d, occ;
    logic                        busy_q, busy_d, done_q, done_d;
    logic                        accept, fire, push;
    logic [LANES-1:0][OUT_W-1:0] lane_q;
    wr_entry_t                   fifo_q [FIFO_DEPTH];
    wr_entry_t                   head;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        prelu_q_lane u_lane (
            .clk   (clk),
            .psum  (bus.s_data[PSUM_LSB + PSUM_W*k +: PSUM_W]),
            .bias  (bias[PSUM_W*k +: PSUM_W]),
            .alpha (alpha[OUT_W*k +: OUT_W]),
            .q     (lane_q[k])
        );
    end

    // Credit check counts beats still in the pipe, so the FIFO can never overflow.
    assign occ          = FCNT_W'(vld_pipe_q[0]) + FCNT_W'(vld_pipe_q[1]);
    assign bus.s_ready  = (state_q == ST_RUN) && (fcnt_q + occ < FCNT_W'(FIFO_DEPTH)) && (acc_q < exp_q);
    assign bus.wr_en    = (fcnt_q != '0);
    assign head         = fifo_q[rptr_q];
    assign bus.wr_addr  = bus.wr_en ? head.addr : '0;
    assign bus.wr_data  = bus.wr_en ? head.data : '0;
    assign busy         = busy_q;
    assign done         = done_q;

    always_comb begin
        accept  = bus.s_valid & bus.s_ready;
        fire    = bus.wr_en & bus.wr_ready;
        push    = vld_pipe_q[1];
        state_d = state_q;
        exp_d   = exp_q;
        base_d  = base_q;
        wid_d   = wid_q;
        acc_d   = acc_q + CNT_W'(accept);
        wcnt_d  = wcnt_q + CNT_W'(fire);
        addr1_d = base_q + 16'(bus.s_data[ROW_LSB +: 8]) * 16'(wid_q) + 16'(bus.s_data[COL_LSB +: 8]);
        wptr_d  = wptr_q + PTR_W'(push);
        rptr_d  = rptr_q + PTR_W'(fire);
        fcnt_d  = fcnt_q + FCNT_W'(push) - FCNT_W'(fire);
        case (state_q)
            ST_IDLE: if (start) begin
                exp_d   = expected_cnt;
                base_d  = out_base_addr;
                wid_d   = out_wid;
                acc_d   = '0;
                wcnt_d  = '0;
                state_d = (expected_cnt == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN:   if (acc_q == exp_q) state_d = ST_DRAIN;
            // Looking at the post-write count lets done follow the last write by one cycle.
            ST_DRAIN: if (wcnt_d == exp_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            exp_q      <= '0;
            base_q     <= '0;
            wid_q      <= '0;
            acc_q      <= '0;
            wcnt_q     <= '0;
            vld_pipe_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fcnt_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            base_q     <= base_d;
            wid_q      <= wid_d;
            acc_q      <= acc_d;
            wcnt_q     <= wcnt_d;
            vld_pipe_q <= {vld_pipe_q[0], accept};
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fcnt_q     <= fcnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        addr1_q <= addr1_d;
        addr2_q <= addr1_q;
        if (push) fifo_q[wptr_q] <= '{addr: addr2_q, data: lane_q};
    end
endmodule

// File: tb/tb_psum_act_writeback.sv
// Directed bench for psum_act_writeback: arithmetic corners, latency, backpressure, reset and FSM edge cases.
module tb_psum_act_writeback;
    import psum_act_writeback_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [15:0]  expected_cnt = '0;
    logic [15:0]  out_base_addr = '0;
    logic [7:0]   out_wid = '0;
    logic [159:0] bias = '0;
    logic [79:0]  alpha = '0;
    logic         busy, done;
    int           checks = 0;
    int           fails = 0;

    psum_act_writeback_if bus();

    psum_act_writeback dut (
        .clk(clk), .rst(rst), .start(start), .expected_cnt(expected_cnt),
        .out_base_addr(out_base_addr), .out_wid(out_wid), .bias(bias), .alpha(alpha),
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] wq_addr[$];
    logic [79:0] wq_data[$];
    int wr_en_seen = 0, done_seen = 0, acc_seen = 0;

    always @(negedge clk) begin
        if (bus.wr_en) wr_en_seen++;
        if (bus.wr_en && bus.wr_ready) begin
            wq_addr.push_back(bus.wr_addr);
            wq_data.push_back(bus.wr_data);
        end
        if (done) done_seen++;
        if (bus.s_valid && bus.s_ready) acc_seen++;
    end

    task automatic clear_mon();
        wq_addr.delete(); wq_data.delete();
        wr_en_seen = 0; done_seen = 0; acc_seen = 0;
    endtask

    task automatic do_start(input logic [15:0] cnt, input logic [15:0] base, input logic [7:0] wid);
        expected_cnt = cnt; out_base_addr = base; out_wid = wid; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [175:0] d, output logic ok);
        int n = 0;
        bus.s_valid = 1'b1; bus.s_data = d;
        @(negedge clk);
        while (!bus.s_ready && n < 300) begin @(negedge clk); n++; end
        ok = bus.s_ready;
        @(posedge clk); #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_done(output logic ok);
        int n = 0;
        while (done_seen == 0 && n < 300) begin @(posedge clk); #1; n++; end
        ok = (done_seen != 0);
        @(posedge clk); #1;
    endtask

    function automatic logic [175:0] mk_beat(input logic [7:0] row, input logic [7:0] col,
                                             input logic [15:0] lane0);
        logic [175:0] d = '0;
        d[15:8] = row; d[7:0] = col; d[16 +: 16] = lane0;
        return d;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0 || bus.wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got s_ready=%b wr_en=%b busy=%b done=%b, required all 0",
                     bus.s_ready, bus.wr_en, busy, done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_positive();
        logic ok;
        logic [79:0] exp_data = 80'h05;
        clear_mon();
        bias = '0; bias[15:0] = 16'h0100;
        alpha = {LANES{8'd64}};
        do_start(16'd1, 16'h0100, 8'd4);
        send_beat(mk_beat(8'd1, 8'd2, 16'h0400), ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL pos_accept: got no s_ready, required beat accepted"); end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b0) begin fails++; $display("FAIL pos_latency_early: got wr_en=%b, required 0", bus.wr_en); end
        @(negedge clk);
        checks++;
        if (bus.wr_en !== 1'b1) begin fails++; $display("FAIL pos_latency: got wr_en=%b, required 1", bus.wr_en); end
        checks++;
        if (bus.wr_addr !== 16'h0106) begin fails++; $display("FAIL pos_addr: got %h, required 0106", bus.wr_addr); end
        checks++;
        if (bus.wr_data !== exp_data) begin fails++; $display("FAIL pos_data: got %h, required %h", bus.wr_data, exp_data); end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin fails++; $display("FAIL pos_done: got done=%b, required 1", done); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL pos_idle: got done=%b busy=%b, required 0 0", done, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_prelu_round();
        logic ok;
        logic [175:0] d;
        logic [79:0] exp_data = '0;
        clear_mon();
        bias = '0;
        alpha = {LANES{8'd64}}; alpha[15:8] = 8'd16;
        d = mk_beat(8'd0, 8'd5, 16'h0000);
        d[16+16*1 +: 16] = 16'hFE00;
        d[16+16*2 +: 16] = 16'hFE00;
        exp_data[15:8] = 8'h00; exp_data[23:16] = 8'hFE;
        do_start(16'd1, 16'h0000, 8'd0);
        send_beat(d, ok);
        wait_done(ok);
        checks++;
        if (!ok || wq_addr.size() != 1) begin
            fails++; $display("FAIL prelu_count: got %0d writes done=%b, required 1 write", wq_addr.size(), ok);
        end else begin
            checks++;
            if (wq_addr[0] !== 16'h0005) begin fails++; $display("FAIL prelu_addr: got %h, required 0005", wq_addr[0]); end
            checks++;
            if (wq_data[0] !== exp_data) begin fails++; $display("FAIL prelu_data: got %h, required %h", wq_data[0], exp_data); end
        end
    endtask

    task automatic test_saturation();
        logic ok;
        logic [175:0] d;
        logic [79:0] exp_data = '0;
        clear_mon();
        bias = '0; bias[16*3 +: 16] = 16'h7FFF; bias[16*4 +: 16] = 16'h8000;
        alpha = {LANES{8'd64}};
        d = mk_beat(8'd2, 8'd1, 16'h0000);
        d[16+16*3 +: 16] = 16'h7FFF;
        d[16+16*4 +: 16] = 16'h8000;
        exp_data[31:24] = 8'h7F; exp_data[39:32] = 8'h80;
        // 0xFFFF + 2*3 + 1 wraps to 0x0006
        do_start(16'd1, 16'hFFFF, 8'd3);
        send_beat(d, ok);
        wait_done(ok);
        checks++;
        if (!ok || wq_addr.size() != 1) begin
            fails++; $display("FAIL sat_count: got %0d writes done=%b, required 1 write", wq_addr.size(), ok);
        end else begin
            checks++;
            if (wq_addr[0] !== 16'h0006) begin fails++; $display("FAIL sat_addr_wrap: got %h, required 0006", wq_addr[0]); end
            checks++;
            if (wq_data[0] !== exp_data) begin fails++; $display("FAIL sat_data: got %h, required %h", wq_data[0], exp_data); end
        end
    endtask

    task automatic test_backpressure();
        logic ok;
        int acc_at = -1;
        logic sr_at = 1'bx;
        logic all_sent = 1'b1;
        clear_mon();
        bias = '0; alpha = {LANES{8'd64}};
        bus.wr_ready = 1'b0;
        do_start(16'd16, 16'h0200, 8'd4);
        fork
            begin
                logic bok;
                for (int i = 0; i < 16; i++) begin
                    send_beat(mk_beat(8'(i >> 2), 8'(i & 3), 16'(i << 8)), bok);
                    if (!bok) all_sent = 1'b0;
                end
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                acc_at = acc_seen; sr_at = bus.s_ready;
                bus.wr_ready = 1'b1;
            end
        join
        checks++;
        if (acc_at != 4 || sr_at !== 1'b0) begin
            fails++; $display("FAIL bp_credit: got %0d accepted s_ready=%b while stalled, required 4 and 0", acc_at, sr_at);
        end
        wait_done(ok);
        checks++;
        if (!ok || !all_sent || wq_addr.size() != 16 || acc_seen != 16) begin
            fails++;
            $display("FAIL bp_count: got %0d writes %0d accepts done=%b sent=%b, required 16 16 1 1",
                     wq_addr.size(), acc_seen, ok, all_sent);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wq_addr[i] !== 16'h0200 + 16'(i) || wq_data[i] !== 80'(i)) begin
                    fails++;
                    $display("FAIL bp_entry%0d: got addr=%h data=%h, required addr=%h data=%h",
                             i, wq_addr[i], wq_data[i], 16'h0200 + 16'(i), 80'(i));
                end
            end
        end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (done_seen != 1) begin fails++; $display("FAIL bp_done_once: got %0d done pulses, required 1", done_seen); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        clear_mon();
        bias = '0; alpha = {LANES{8'd64}};
        bus.wr_ready = 1'b0;
        do_start(16'd8, 16'h0400, 8'd1);
        for (int i = 0; i < 3; i++) send_beat(mk_beat(8'd0, 8'(i), 16'((i + 1) << 8)), ok);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.s_ready !== 1'b0 || bus.wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            bus.wr_addr !== 16'h0 || bus.wr_data !== 80'h0) begin
            fails++;
            $display("FAIL midrst_outputs: got s_ready=%b wr_en=%b busy=%b done=%b addr=%h data=%h, required all 0",
                     bus.s_ready, bus.wr_en, busy, done, bus.wr_addr, bus.wr_data);
        end
        @(posedge clk); #1;
        wr_en_seen = 0;
        bus.wr_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        checks++;
        if (wr_en_seen != 0 || wq_addr.size() != 0) begin
            fails++; $display("FAIL midrst_nowrite: got %0d wr_en cycles %0d writes, required 0 0", wr_en_seen, wq_addr.size());
        end
        clear_mon();
        do_start(16'd2, 16'h0500, 8'd1);
        send_beat(mk_beat(8'd0, 8'd0, 16'h0700), ok);
        send_beat(mk_beat(8'd0, 8'd1, 16'h0800), ok);
        wait_done(ok);
        checks++;
        if (!ok || wq_addr.size() != 2) begin
            fails++; $display("FAIL midrst_restart: got %0d writes done=%b, required 2 writes", wq_addr.size(), ok);
        end else begin
            checks++;
            if (wq_addr[0] !== 16'h0500 || wq_data[0] !== 80'h07 || wq_addr[1] !== 16'h0501 || wq_data[1] !== 80'h08) begin
                fails++;
                $display("FAIL midrst_restart_data: got %h/%h %h/%h, required 0500/07 0501/08",
                         wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
            end
        end
    endtask

    task automatic test_cnt0_and_ignored_start();
        logic ok;
        clear_mon();
        do_start(16'd0, 16'h1234, 8'd9);
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin fails++; $display("FAIL cnt0_done: got done=%b, required 1", done); end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL cnt0_idle: got done=%b busy=%b, required 0 0", done, busy); end
        repeat (3) @(posedge clk); #1;
        checks++;
        if (wr_en_seen != 0) begin fails++; $display("FAIL cnt0_nowrite: got %0d wr_en cycles, required 0", wr_en_seen); end

        clear_mon();
        do_start(16'd2, 16'h0300, 8'd8);
        do_start(16'd5, 16'h0000, 8'd0);
        send_beat(mk_beat(8'd1, 8'd0, 16'h0200), ok);
        send_beat(mk_beat(8'd0, 8'd3, 16'h0200), ok);
        wait_done(ok);
        checks++;
        if (!ok || wq_addr.size() != 2 || busy !== 1'b0) begin
            fails++; $display("FAIL ign_start_count: got %0d writes done=%b busy=%b, required 2 1 0", wq_addr.size(), ok, busy);
        end else begin
            checks++;
            if (wq_addr[0] !== 16'h0308 || wq_addr[1] !== 16'h0303 || wq_data[0] !== 80'h02 || wq_data[1] !== 80'h02) begin
                fails++;
                $display("FAIL ign_start_cfg: got %h/%h %h/%h, required 0308/02 0303/02",
                         wq_addr[0], wq_data[0], wq_addr[1], wq_data[1]);
            end
        end
    endtask

    initial begin
        bus.s_valid = 1'b0; bus.s_data = '0; bus.wr_ready = 1'b1;
        test_reset();
        test_positive();
        test_prelu_round();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_cnt0_and_ignored_start();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required summary before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
